uart_hex_loader: RTL and testbench

UART_HEX_LOADER -- requirements
Module: uart_hex_loader

---
 rtl/uart_loader_pkg.sv | 19 +
 rtl/hex_ascii_decode.sv | 24 ++
 rtl/uart_hex_loader.sv | 146 ++++++++++++++
 tb/tb_uart_hex_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared constants and state encoding for the UART hex loader.
package uart_loader_pkg;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_UP_A  = 8'h41;
  localparam logic [7:0] ASCII_UP_F  = 8'h46;
  localparam logic [7:0] ASCII_LOW_A = 8'h61;
  localparam logic [7:0] ASCII_LOW_F = 8'h66;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } loader_state_e;

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: byte in, nibble and is_hex out.
module hex_ascii_decode
  import uart_loader_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [3:0] o_nib,
  output logic       o_is_hex
);

  always_comb begin
    o_nib    = 4'd0;
    o_is_hex = 1'b0;
    if (i_byte >= ASCII_0 && i_byte <= ASCII_9) begin
      o_nib    = i_byte[3:0];
      o_is_hex = 1'b1;
    end else if ((i_byte >= ASCII_UP_A && i_byte <= ASCII_UP_F) ||
                 (i_byte >= ASCII_LOW_A && i_byte <= ASCII_LOW_F)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
      o_nib    = i_byte[3:0] + 4'd9;
      o_is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/uart_hex_loader.sv
// Assembles ASCII hex digits from a UART receiver into memory words,
// optionally echoing every consumed byte back to the transmitter.
module uart_hex_loader
  import uart_loader_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 4,
  parameter int WRAP   = 0,
  parameter int ECHO   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic              rx_clr,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [3:0]        disp_nib,
  output logic              full,
  output logic              bad_char
);

  localparam int                NIBS      = WORD_W / 4;
  localparam int                CNT_W     = $clog2(NIBS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NIBS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  loader_state_e     r_state;
  loader_state_e     w_state_next;
  logic              w_consume;
  logic [3:0]        w_nib;
  logic              w_is_hex;
  logic [WORD_W-1:0] w_acc_shift;

  logic              r_rx_clr;
  logic              r_tx_wr;
  logic [7:0]        r_tx_data;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic [3:0]        r_disp;
  logic              r_full;
  logic              r_bad;
  logic [WORD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;

  hex_ascii_decode u_dec (
    .i_byte   (rx_data),
    .o_nib    (w_nib),
    .o_is_hex (w_is_hex)
  );

  assign w_acc_shift = {r_acc[WORD_W-5:0], w_nib};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // DRAIN waits for the receiver to drop rx_rdy after our rx_clr pulse.
  always_comb begin
    w_state_next = r_state;
    w_consume    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_rdy && !tx_busy) begin
          w_consume    = 1'b1;
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!rx_rdy) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_clr    <= 1'b0;
      r_tx_wr     <= 1'b0;
      r_tx_data   <= 8'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_disp      <= 4'd0;
      r_full      <= 1'b0;
      r_bad       <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
    end else begin
      r_rx_clr <= w_consume;
      r_tx_wr  <= w_consume && (ECHO != 0);
      r_mem_we <= 1'b0;
      if (w_consume) begin
        if (ECHO != 0) r_tx_data <= rx_data;
        if (w_is_hex) begin
          if (!r_full) begin
            r_acc  <= w_acc_shift;
            r_disp <= w_nib;
            if (r_cnt == CNT_LAST) begin
              r_cnt       <= '0;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_addr;
              r_mem_wdata <= w_acc_shift;
              if (r_addr == ADDR_LAST) begin
                if (WRAP != 0) r_addr <= '0;
                else           r_full <= 1'b1;
              end else begin
                r_addr <= r_addr + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end else if (rx_data == ASCII_CR || rx_data == ASCII_LF) begin
          r_cnt <= '0;
        end else if (rx_data == ASCII_ESC) begin
          r_addr <= '0;
          r_cnt  <= '0;
          r_full <= 1'b0;
          r_bad  <= 1'b0;
        end else begin
          r_bad <= 1'b1;
        end
      end
    end
  end

  assign rx_clr    = r_rx_clr;
  assign tx_wr     = r_tx_wr;
  assign tx_data   = r_tx_data;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign disp_nib  = r_disp;
  assign full      = r_full;
  assign bad_char  = r_bad;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Drives two loaders (WRAP=0/ECHO=1 and WRAP=1/ECHO=0) with the same byte
// stream and compares them against a per-byte reference model.
module tb_uart_hex_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic rx_rdy = 1'b0;
  logic tx_busy = 1'b0;

  logic [1:0]       clr_v, txwr_v, we_v, full_v, bad_v;
  logic [1:0][7:0]  txd_v;
  logic [1:0][1:0]  addr_v;
  logic [1:0][31:0] data_v;
  logic [1:0][3:0]  disp_v;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_word[2];
  logic [31:0] m_last_data[2];
  int          m_addr[2], m_cnt[2], m_last_addr[2];
  bit          m_full[2], m_bad[2], e_we[2];
  logic [3:0]  m_disp[2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    uart_hex_loader #(
      .WORD_W (32),
      .ADDR_W (2),
      .WRAP   (gi),
      .ECHO   (1 - gi)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_rdy    (rx_rdy),
      .rx_clr    (clr_v[gi]),
      .tx_busy   (tx_busy),
      .tx_data   (txd_v[gi]),
      .tx_wr     (txwr_v[gi]),
      .mem_we    (we_v[gi]),
      .mem_addr  (addr_v[gi]),
      .mem_wdata (data_v[gi]),
      .disp_nib  (disp_v[gi]),
      .full      (full_v[gi]),
      .bad_char  (bad_v[gi])
    );
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_word[k] = 0; m_last_data[k] = 0; m_addr[k] = 0; m_cnt[k] = 0;
      m_last_addr[k] = 0; m_full[k] = 0; m_bad[k] = 0; e_we[k] = 0; m_disp[k] = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit hex;
    int v;
    hex = 1'b1;
    v = 0;
    if (b >= "0" && b <= "9")      v = b - 8'h30;
    else if (b >= "A" && b <= "F") v = b - 8'h41 + 10;
    else if (b >= "a" && b <= "f") v = b - 8'h61 + 10;
    else                           hex = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e_we[k] = 1'b0;
      if (hex) begin
        if (!m_full[k]) begin
          m_word[k] = (m_word[k] * 16) + v;
          m_disp[k] = v[3:0];
          m_cnt[k]++;
          if (m_cnt[k] == 8) begin
            m_cnt[k] = 0;
            e_we[k] = 1'b1;
            m_last_addr[k] = m_addr[k];
            m_last_data[k] = m_word[k];
            if (m_addr[k] == 3) begin
              if (k == 1) m_addr[k] = 0;
              else        m_full[k] = 1'b1;
            end else begin
              m_addr[k]++;
            end
          end
        end
      end else if (b == 8'h0D || b == 8'h0A) begin
        m_cnt[k] = 0;
      end else if (b == 8'h1B) begin
        m_addr[k] = 0; m_cnt[k] = 0; m_full[k] = 1'b0; m_bad[k] = 1'b0;
      end else begin
        m_bad[k] = 1'b1;
      end
    end
  endtask

  task automatic check_state(input string pfx);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("%s_we%0d", pfx, k), we_v[k], e_we[k]);
      check_val($sformatf("%s_addr%0d", pfx, k), addr_v[k], m_last_addr[k]);
      check_val($sformatf("%s_wdata%0d", pfx, k), data_v[k], m_last_data[k]);
      check_val($sformatf("%s_full%0d", pfx, k), full_v[k], m_full[k]);
      check_val($sformatf("%s_bad%0d", pfx, k), bad_v[k], m_bad[k]);
      check_val($sformatf("%s_disp%0d", pfx, k), disp_v[k], m_disp[k]);
    end
  endtask

  task automatic do_reset(input logic [7:0] pending);
    @(negedge clk);
    rst = 1'b1;
    rx_data = pending;
    rx_rdy = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_val("rst_clr", clr_v, 2'b00);
    check_val("rst_txwr", txwr_v, 2'b00);
    check_val("rst_txd", txd_v, 16'h0);
    check_state("rst");
    @(negedge clk);
    rst = 1'b0;
    rx_rdy = 1'b0;
    $display("reset (pending byte %02h)", pending);
  endtask

  task automatic send(input logic [7:0] b, input int busy_cycles);
    int waited;
    @(negedge clk);
    rx_data = b;
    rx_rdy = 1'b1;
    tx_busy = (busy_cycles > 0);
    for (int i = 0; i < busy_cycles; i++) begin
      @(posedge clk);
      #1;
      check_val("busy_clr", clr_v, 2'b00);
      check_val("busy_we", we_v, 2'b00);
    end
    if (busy_cycles > 0) begin
      @(negedge clk);
      tx_busy = 1'b0;
    end
    model_byte(b);
    waited = 9;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (clr_v[0]) begin
        waited = i;
        break;
      end
    end
    check_val("clr_latency", waited, 1);
    check_val("clr_b", clr_v[1], 1'b1);
    check_val("echo_wr", txwr_v[0], 1'b1);
    check_val("echo_data", txd_v[0], b);
    check_val("noecho_wr", txwr_v[1], 1'b0);
    check_state("byte");
    rx_rdy = 1'b0;
    @(posedge clk);
    #1;
    check_val("pulse_clr", clr_v, 2'b00);
    check_val("pulse_txwr", txwr_v, 2'b00);
    check_val("pulse_we", we_v, 2'b00);
    $display("byte %02h busy=%0d we=%b addr=%0d/%0d data=%08h/%08h full=%b bad=%b",
             b, busy_cycles, we_v, addr_v[0], addr_v[1], data_v[0], data_v[1], full_v, bad_v);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    string hexs;
    int r;
    logic [7:0] b;
    hexs = "0123456789ABCDEFabcdef";
    model_reset();
    do_reset(8'h00);

    send_str("DEADbeef");
    check_val("deadbeef_word", data_v[0], 32'hDEADBEEF);
    check_val("deadbeef_disp", disp_v[0], 4'hF);
    send(8'h1B, 0);

    send_str("12");
    send(8'h0D, 0);
    send_str("0000000A");
    check_val("cr_word", data_v[0], 32'h0000000A);
    send(8'h1B, 0);

    send_str("12Z34567");
    send_str("8");
    check_val("badz_word", data_v[0], 32'h12345678);
    check_val("badz_flag", bad_v[0], 1'b1);
    send(8'h1B, 0);

    for (int w = 0; w < 5; w++)
      for (int i = 0; i < 8; i++) send(hexs[$urandom_range(0, 21)], 0);
    check_val("full_set", full_v[0], 1'b1);
    check_val("wrap_addr", addr_v[1], 2'd0);
    send(8'h1B, 0);
    check_val("esc_full", full_v[0], 1'b0);

    send("5", 5);

    send_str("12345");
    do_reset("7");
    send_str("89abcdef");
    check_val("post_rst_word", data_v[0], 32'h89ABCDEF);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 72)      b = hexs[$urandom_range(0, 21)];
      else if (r < 77) b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
      else if (r < 80) b = 8'h1B;
      else if (r < 82) b = 8'h00;
      else             b = 8'($urandom_range(0, 255));
      if (r == 81) do_reset(b);
      else         send(b, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
